// File: rtl/fir_band_scheduler_if.sv
// Bundle of the sample-source, shared-MAC and result signals around fir_band_scheduler.
// The master modport is the scheduler's view; slave is the surrounding datapath.
interface fir_band_scheduler_if #(
  parameter int unsigned NUM_BANDS = 4,
  parameter int unsigned TAPS      = 32,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ACC_W     = 64
);
  localparam int unsigned BandW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int unsigned TapW  = $clog2(TAPS);

  logic              enable;
  logic [DATA_W-1:0] sample_in;
  logic [ACC_W-1:0]  mac_acc;
  logic              shift_en;
  logic [DATA_W-1:0] new_sample;
  logic [BandW-1:0]  band_sel;
  logic [TapW-1:0]   tap_addr;
  logic              mac_clr;
  logic              mac_en;
  logic [ACC_W-1:0]  result_out;
  logic [BandW-1:0]  result_band;
  logic              result_valid;
  logic              frame_done;
  logic              busy;
  logic              overrun;

  modport master (
    input  enable, sample_in, mac_acc,
    output shift_en, new_sample, band_sel, tap_addr, mac_clr, mac_en,
    output result_out, result_band, result_valid, frame_done, busy, overrun
  );

  modport slave (
    output enable, sample_in, mac_acc,
    input  shift_en, new_sample, band_sel, tap_addr, mac_clr, mac_en,
    input  result_out, result_band, result_valid, frame_done, busy, overrun
  );
endinterface

// File: rtl/fir_band_scheduler.sv
// Time-shares one external MAC among NUM_BANDS FIR bands: one delay-line shift per sample
// tick, then a clear/accumulate/drain/store pass per band with a tagged result.
module fir_band_scheduler #(
  parameter int unsigned NUM_BANDS  = 4,
  parameter int unsigned TAPS       = 32,
  parameter int unsigned MAC_LAT    = 2,
  parameter int unsigned SAMPLE_DIV = 10000,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ACC_W      = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  fir_band_scheduler_if.master bus
);
  localparam int unsigned BandW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int unsigned TapW  = $clog2(TAPS);
  localparam int unsigned DivW  = $clog2(SAMPLE_DIV);
  localparam int unsigned LatW  = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {StIdle, StShift, StClear, StMac, StDrain, StStore} state_e;

  state_e            state_q;
  logic [DivW-1:0]   div_cnt_q;
  logic [BandW-1:0]  band_q;
  logic [TapW-1:0]   tap_q;
  logic [LatW-1:0]   lat_q;
  logic              shift_en_q, mac_clr_q, mac_en_q;
  logic [DATA_W-1:0] new_sample_q;
  logic [ACC_W-1:0]  result_out_q;
  logic [BandW-1:0]  result_band_q;
  logic              result_valid_q, frame_done_q, overrun_q;
  logic              tick;

  assign tick = bus.enable && (div_cnt_q == DivW'(SAMPLE_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      div_cnt_q      <= '0;
      band_q         <= '0;
      tap_q          <= '0;
      lat_q          <= '0;
      shift_en_q     <= 1'b0;
      mac_clr_q      <= 1'b0;
      mac_en_q       <= 1'b0;
      new_sample_q   <= '0;
      result_out_q   <= '0;
      result_band_q  <= '0;
      result_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      if (!bus.enable || tick) begin
        div_cnt_q <= '0;
      end else begin
        div_cnt_q <= div_cnt_q + DivW'(1);
      end
      if (tick) begin
        new_sample_q <= bus.sample_in;
      end
      // Ticks outside IDLE (including the STORE->IDLE cycle) are dropped, not queued.
      if (tick && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
      shift_en_q     <= 1'b0;
      mac_clr_q      <= 1'b0;
      result_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (tick) begin
            shift_en_q <= 1'b1;
            state_q    <= StShift;
          end
        end
        StShift: begin
          band_q    <= '0;
          mac_clr_q <= 1'b1;
          state_q   <= StClear;
        end
        StClear: begin
          tap_q    <= '0;
          mac_en_q <= 1'b1;
          state_q  <= StMac;
        end
        StMac: begin
          // TAPS is a power of two, so the last increment wraps tap_addr back to 0.
          tap_q <= tap_q + TapW'(1);
          if (tap_q == TapW'(TAPS - 1)) begin
            mac_en_q <= 1'b0;
            lat_q    <= '0;
            state_q  <= (MAC_LAT == 0) ? StStore : StDrain;
          end
        end
        StDrain: begin
          lat_q <= lat_q + LatW'(1);
          if (lat_q == LatW'(MAC_LAT - 1)) begin
            state_q <= StStore;
          end
        end
        StStore: begin
          result_out_q   <= bus.mac_acc;
          result_band_q  <= band_q;
          result_valid_q <= 1'b1;
          if (band_q == BandW'(NUM_BANDS - 1)) begin
            frame_done_q <= 1'b1;
            state_q      <= StIdle;
          end else begin
            band_q    <= band_q + BandW'(1);
            mac_clr_q <= 1'b1;
            state_q   <= StClear;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.shift_en     = shift_en_q;
  assign bus.new_sample   = new_sample_q;
  assign bus.band_sel     = band_q;
  assign bus.tap_addr     = tap_q;
  assign bus.mac_clr      = mac_clr_q;
  assign bus.mac_en       = mac_en_q;
  assign bus.result_out   = result_out_q;
  assign bus.result_band  = result_band_q;
  assign bus.result_valid = result_valid_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.busy         = (state_q != StIdle);
  assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_fir_band_scheduler.sv
// Bench for fir_band_scheduler: behavioural delay line + pipelined MAC, and a scoreboard of
// per-band sums pushed at each shift and popped at each result_valid.
module tb_fir_band_scheduler;
  localparam int unsigned NB = 2;
  localparam int unsigned TP = 4;
  localparam int unsigned ML = 2;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 64;
  localparam int unsigned PER = TP + ML + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, rst_b, force_ones, pre_en;
  logic [DW-1:0] pre_data;

  fir_band_scheduler_if #(.NUM_BANDS(NB), .TAPS(TP), .DATA_W(DW), .ACC_W(AW)) a_if ();
  fir_band_scheduler_if #(.NUM_BANDS(NB), .TAPS(TP), .DATA_W(DW), .ACC_W(AW)) b_if ();

  fir_band_scheduler #(
    .NUM_BANDS(NB), .TAPS(TP), .MAC_LAT(ML), .SAMPLE_DIV(32), .DATA_W(DW), .ACC_W(AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (a_if.master)
  );

  // Deliberately too-fast divider so a tick lands mid-frame.
  fir_band_scheduler #(
    .NUM_BANDS(NB), .TAPS(TP), .MAC_LAT(ML), .SAMPLE_DIV(10), .DATA_W(DW), .ACC_W(AW)
  ) dut_b (
    .clk  (clk),
    .reset(rst_b),
    .bus  (b_if.master)
  );

  // External datapath model for instance A.
  logic [DW-1:0] dl   [TP];
  logic [AW-1:0] pipe [ML];
  logic [AW-1:0] acc;

  function automatic logic [AW-1:0] coef(input int b, input int t);
    return (b == 0) ? AW'(1) : AW'(t + 1);
  endfunction

  always @(posedge clk) begin
    if (pre_en || a_if.shift_en) begin
      for (int i = TP - 1; i > 0; i--) dl[i] <= dl[i-1];
      dl[0] <= pre_en ? pre_data : a_if.new_sample;
    end
    pipe[0] <= a_if.mac_en ?
               coef(int'(a_if.band_sel), int'(a_if.tap_addr)) * AW'(dl[a_if.tap_addr]) : '0;
    for (int i = 1; i < ML; i++) pipe[i] <= pipe[i-1];
    if (a_if.mac_clr) acc <= '0;
    else              acc <= acc + pipe[ML-1];
  end

  assign a_if.mac_acc = force_ones ? '1 : acc;
  assign b_if.mac_acc = 64'hABCD;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic          band;
    logic [AW-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   valid_cnt = 0;

  always @(negedge clk) begin : monitor
    logic [AW-1:0] e;
    exp_t          x;
    if (!reset && a_if.shift_en) begin
      for (int b = 0; b < int'(NB); b++) begin
        e = '0;
        for (int i = 0; i < int'(TP); i++) begin
          if (i == 0) e += coef(b, i) * AW'(a_if.new_sample);
          else        e += coef(b, i) * AW'(dl[i-1]);
        end
        sb.push_back('{band: b[0], val: (force_ones ? '1 : e)});
      end
    end
    if (!reset && a_if.result_valid) begin
      valid_cnt++;
      check_eq("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        x = sb.pop_front();
        check_eq("sb_result_out", a_if.result_out, x.val);
        check_eq("sb_result_band", 64'(a_if.result_band), 64'(x.band));
      end
    end
  end

  int cyc;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_a();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    sb.delete();
  endtask

  function automatic logic [8:0] strobes();
    return {a_if.shift_en, a_if.mac_clr, a_if.mac_en, a_if.tap_addr, a_if.band_sel,
            a_if.result_valid, a_if.frame_done, a_if.busy};
  endfunction

  // Expected strobes at cycle c of a frame whose SHIFT cycle is t0.
  function automatic logic [8:0] exp_vec(input int c, input int t0);
    logic sh, clr, en, rv, fd, bs, bz;
    logic [1:0] ta;
    int base;
    sh = (c == t0);
    bs = (c >= t0 + 1 + int'(PER));
    bz = (c >= t0) && (c <= t0 + int'(NB * PER));
    clr = 1'b0; en = 1'b0; rv = 1'b0; fd = 1'b0; ta = 2'd0;
    for (int k = 0; k < int'(NB); k++) begin
      base = t0 + 1 + k * int'(PER);
      if (c == base) clr = 1'b1;
      if (c > base && c <= base + int'(TP)) begin
        en = 1'b1;
        ta = 2'(c - base - 1);
      end
      if (c == base + int'(PER)) begin
        rv = 1'b1;
        fd = (k == int'(NB) - 1);
      end
    end
    return {sh, clr, en, ta, bs, rv, fd, bz};
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n, r, v0, shifts, vb;
    reset = 1'b1; rst_b = 1'b1; force_ones = 1'b0; pre_en = 1'b0; pre_data = '0;
    a_if.enable = 1'b0; a_if.sample_in = '0;
    b_if.enable = 1'b0; b_if.sample_in = '0;
    cyc = 0;

    // Preload delay line by shifting 1,2,3,4 so it holds 4,3,2,1.
    for (int i = 1; i <= 4; i++) begin
      pre_en = 1'b1; pre_data = DW'(i);
      @(posedge clk); #1;
    end
    pre_en = 1'b0;

    // Frame timing and arithmetic.
    reset_a();
    a_if.enable = 1'b1; a_if.sample_in = 16'h0005;
    check_eq("s1_rst_result", a_if.result_out, 64'd0);
    check_eq("s1_rst_overrun", 64'(a_if.overrun), 64'd0);
    for (int c = 0; c <= 52; c++) begin
      check_eq($sformatf("s1_vec_c%0d", cyc), 64'(strobes()), 64'(exp_vec(cyc, 32)));
      if (cyc == 32) check_eq("s1_new_sample", 64'(a_if.new_sample), 64'd5);
      if (cyc == 41) begin
        check_eq("s2_band0_sum", a_if.result_out, 64'd14);
        check_eq("s2_band0_tag", 64'(a_if.result_band), 64'd0);
      end
      if (cyc == 49) begin
        check_eq("s2_band1_sum", a_if.result_out, 64'd30);
        check_eq("s2_band1_tag", 64'(a_if.result_band), 64'd1);
      end
      step();
    end

    // Reset mid-MAC.
    reset_a();
    a_if.enable = 1'b1; a_if.sample_in = 16'h0007;
    while (cyc < 36) step();
    reset = 1'b1;
    step();
    check_eq("s4_strobes_zero", 64'(strobes()), 64'd0);
    check_eq("s4_result_zero", a_if.result_out, 64'd0);
    check_eq("s4_sample_zero", 64'(a_if.new_sample), 64'd0);
    reset = 1'b0; cyc = 0; sb.delete(); v0 = valid_cnt;
    n = 0;
    while (!a_if.shift_en && n < 100) begin step(); n++; end
    check_eq("s4_shift_seen", 64'(a_if.shift_en), 64'd1);
    check_eq("s4_shift_cycle", 64'(cyc), 64'd32);
    check_eq("s4_no_valid", 64'(valid_cnt - v0), 64'd0);
    while (cyc < 50) step();
    check_eq("s4_frame_valids", 64'(valid_cnt - v0), 64'd2);

    // Enable dropped mid-frame.
    reset_a();
    a_if.enable = 1'b1; a_if.sample_in = 16'h0009;
    for (int c = 0; c <= 49; c++) begin
      if (cyc == 35) a_if.enable = 1'b0;
      if (cyc >= 32) check_eq($sformatf("s5_vec_c%0d", cyc), 64'(strobes()),
                              64'(exp_vec(cyc, 32)));
      step();
    end
    shifts = 0;
    while (cyc < 80) begin
      if (a_if.shift_en) shifts++;
      step();
    end
    check_eq("s5_no_ticks", 64'(shifts), 64'd0);
    check_eq("s5_div_zero", 64'(dut.div_cnt_q), 64'd0);
    a_if.sample_in = 16'h0022; a_if.enable = 1'b1; r = cyc;
    n = 0;
    while (!a_if.shift_en && n < 100) begin step(); n++; end
    check_eq("s5_reenable_shift", 64'(cyc - r), 64'd32);
    check_eq("s5_new_sample", 64'(a_if.new_sample), 64'h22);
    n = 0;
    while (!a_if.frame_done && n < 40) begin step(); n++; end
    check_eq("s5_frame_done", 64'(a_if.frame_done), 64'd1);

    // All-ones accumulator passes through untruncated.
    step();
    force_ones = 1'b1;
    n = 0;
    while (!a_if.shift_en && n < 64) begin step(); n++; end
    check_eq("s6_shift_seen", 64'(a_if.shift_en), 64'd1);
    n = 0;
    while (!a_if.frame_done && n < 40) begin step(); n++; end
    check_eq("s6_result_ones", a_if.result_out, 64'hFFFF_FFFF_FFFF_FFFF);
    force_ones = 1'b0; a_if.enable = 1'b0;
    step(); step();
    check_eq("sb_drained", 64'(sb.size()), 64'd0);

    // Overrun on instance B.
    b_if.enable = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0; cyc = 0; shifts = 0; vb = 0;
    for (int c = 0; c <= 31; c++) begin
      if (cyc == 10) check_eq("s3_first_shift", 64'(b_if.shift_en), 64'd1);
      if (cyc > 10 && cyc <= 27 && b_if.shift_en) shifts++;
      if (b_if.result_valid) begin
        check_eq("s3_band_tag", 64'(b_if.result_band), 64'(vb));
        check_eq("s3_result", b_if.result_out, 64'hABCD);
        vb++;
      end
      if (cyc == 19) check_eq("s3_overrun_pre", 64'(b_if.overrun), 64'd0);
      if (cyc == 20) check_eq("s3_overrun_set", 64'(b_if.overrun), 64'd1);
      if (cyc == 27) check_eq("s3_frame_done", 64'(b_if.frame_done), 64'd1);
      if (cyc == 30) check_eq("s3_next_shift", 64'(b_if.shift_en), 64'd1);
      if (cyc == 31) check_eq("s3_overrun_held", 64'(b_if.overrun), 64'd1);
      step();
    end
    check_eq("s3_no_extra_shift", 64'(shifts), 64'd0);
    check_eq("s3_both_results", 64'(vb), 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
